traffic_phase_ctrl: RTL and testbench

- Phase sequencer for the crossroad traffic light. Divides clk_50MHz to a 1 Hz tick and runs the NS/EW phase FSM with per-phase countdowns.
- Services latched pedestrian requests and provides a night flashing-yellow mode.
- Drives the 6-bit lamp vector and the remaining-seconds value, in binary and BCD, for the seven-segment scanner downstream.

---
 rtl/traffic_pkg.sv | 50 +++++
 rtl/tick_gen.sv | 29 ++
 rtl/traffic_phase_ctrl.sv | 112 +++++++++++
 tb/tb_traffic_phase_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - state codes, lamp patterns and BCD helper for the crossroad phase sequencer
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    RED_A = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    RED_B = 3'd5,
    FLASH = 3'd6
  } state_t;

  // [5:3] NS {red,yellow,green}, [2:0] EW {red,yellow,green}
  localparam logic [5:0] LAMP_NS_G   = 6'b001100;
  localparam logic [5:0] LAMP_NS_Y   = 6'b010100;
  localparam logic [5:0] LAMP_ALLRED = 6'b100100;
  localparam logic [5:0] LAMP_EW_G   = 6'b100001;
  localparam logic [5:0] LAMP_EW_Y   = 6'b100010;
  localparam logic [5:0] LAMP_FLASH  = 6'b010010;
  localparam logic [5:0] LAMP_OFF    = 6'b000000;

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  function automatic state_t next_of(input state_t s);
    case (s)
      RED_B:   return NS_G;
      NS_G:    return NS_Y;
      NS_Y:    return RED_A;
      RED_A:   return EW_G;
      EW_G:    return EW_Y;
      EW_Y:    return RED_B;
      default: return RED_B;
    endcase
  endfunction

  function automatic logic [5:0] lamp_of(input state_t s, input logic flash_ph);
    case (s)
      NS_G:         return LAMP_NS_G;
      NS_Y:         return LAMP_NS_Y;
      RED_A, RED_B: return LAMP_ALLRED;
      EW_G:         return LAMP_EW_G;
      EW_Y:         return LAMP_EW_Y;
      default:      return flash_ph ? LAMP_FLASH : LAMP_OFF;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - divides the system clock down to a one-cycle pulse every TICK_DIV cycles
module tick_gen
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk_50MHz,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] tick_cnt;

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  assign tick = (tick_cnt == LAST);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - NS/EW phase FSM with per-phase countdown, pedestrian shortening and night flash
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned T_GREEN   = 30,
  parameter int unsigned T_YELLOW  = 3,
  parameter int unsigned T_ALLRED  = 2,
  parameter int unsigned T_PED_REM = 5
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       ped_req_ns,
  input  logic       ped_req_ew,
  input  logic       night,
  output logic [5:0] light,
  output logic [2:0] phase,
  output logic [6:0] remain,
  output logic [7:0] remain_bcd,
  output logic       tick_1hz
);

  localparam logic [6:0] D_GREEN   = 7'(T_GREEN);
  localparam logic [6:0] D_YELLOW  = 7'(T_YELLOW);
  localparam logic [6:0] D_ALLRED  = 7'(T_ALLRED);
  localparam logic [6:0] D_PED_REM = 7'(T_PED_REM);

  logic       tick;
  state_t     state, state_n;
  logic [6:0] remain_n;
  logic       flash_ph, flash_n;
  logic       pend_ns, pend_ns_n;
  logic       pend_ew, pend_ew_n;
  logic       enter_ns_g, enter_ew_g;

  function automatic logic [6:0] dur_of(input state_t s);
    case (s)
      NS_G, EW_G: return D_GREEN;
      NS_Y, EW_Y: return D_YELLOW;
      default:    return D_ALLRED;
    endcase
  endfunction

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .tick      (tick)
  );

  assign tick_1hz = tick;
  assign phase    = state;

  // Priority on a tick: night entry/exit, then expiry, then pedestrian shortening, then decrement.
  always_comb begin
    state_n  = state;
    remain_n = remain;
    flash_n  = flash_ph;
    if (tick) begin
      if (state == FLASH) begin
        if (night) begin
          flash_n = ~flash_ph;
        end else begin
          state_n  = RED_B;
          remain_n = D_ALLRED;
          flash_n  = 1'b0;
        end
      end else if (night) begin
        state_n  = FLASH;
        remain_n = 7'd0;
        flash_n  = 1'b1;
      end else if (remain <= 7'd1) begin
        state_n  = next_of(state);
        remain_n = dur_of(state_n);
      end else if (state == NS_G && pend_ns && remain > D_PED_REM) begin
        remain_n = D_PED_REM;
      end else if (state == EW_G && pend_ew && remain > D_PED_REM) begin
        remain_n = D_PED_REM;
      end else begin
        remain_n = remain - 7'd1;
      end
    end
  end

  // A request in the same cycle as the clearing entry must survive, so set is ORed in last.
  always_comb begin
    enter_ns_g = (state_n == NS_G) && (state != NS_G);
    enter_ew_g = (state_n == EW_G) && (state != EW_G);
    pend_ew_n  = ped_req_ew | (pend_ew & ~enter_ns_g);
    pend_ns_n  = ped_req_ns | (pend_ns & ~enter_ew_g);
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state      <= RED_B;
      remain     <= D_ALLRED;
      flash_ph   <= 1'b0;
      pend_ns    <= 1'b0;
      pend_ew    <= 1'b0;
      light      <= LAMP_ALLRED;
      remain_bcd <= to_bcd(D_ALLRED);
    end else begin
      state      <= state_n;
      remain     <= remain_n;
      flash_ph   <= flash_n;
      pend_ns    <= pend_ns_n;
      pend_ew    <= pend_ew_n;
      light      <= lamp_of(state_n, flash_n);
      remain_bcd <= to_bcd(remain_n);
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - scoreboard bench for the crossroad phase sequencer
module tb_traffic_phase_ctrl;

  logic       clk_50MHz = 1'b0;
  logic       reset = 1'b1;
  logic       ped_req_ns = 1'b0;
  logic       ped_req_ew = 1'b0;
  logic       night = 1'b0;
  logic [5:0] light;
  logic [2:0] phase;
  logic [6:0] remain;
  logic [7:0] remain_bcd;
  logic       tick_1hz;

  typedef struct packed {
    logic [2:0] ph;
    logic [5:0] lt;
    logic [6:0] rm;
    logic [7:0] bcd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  traffic_phase_ctrl #(.TICK_DIV(4)) dut (
    .clk_50MHz  (clk_50MHz),
    .reset      (reset),
    .ped_req_ns (ped_req_ns),
    .ped_req_ew (ped_req_ew),
    .night      (night),
    .light      (light),
    .phase      (phase),
    .remain     (remain),
    .remain_bcd (remain_bcd),
    .tick_1hz   (tick_1hz)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  function automatic exp_t mk(input logic [2:0] ph, input int rm, input logic fph);
    exp_t e;
    e.ph  = ph;
    e.rm  = 7'(rm);
    e.bcd = {4'(rm / 10), 4'(rm % 10)};
    case (ph)
      3'd0:       e.lt = 6'b001100;
      3'd1:       e.lt = 6'b010100;
      3'd2, 3'd5: e.lt = 6'b100100;
      3'd3:       e.lt = 6'b100001;
      3'd4:       e.lt = 6'b100010;
      default:    e.lt = fph ? 6'b010010 : 6'b000000;
    endcase
    return e;
  endfunction

  task automatic push_run(input logic [2:0] ph, input int from, input int to);
    for (int r = from; r >= to; r--) sb.push_back(mk(ph, r, 1'b0));
  endtask

  // Called at a negedge; returns at the negedge just after the next tick edge.
  task automatic wait_tick();
    int n = 0;
    while (tick_1hz !== 1'b1 && n < 8) begin
      @(negedge clk_50MHz);
      n++;
    end
    checks++;
    if (n >= 8) begin
      errors++;
      $display("FAIL tick_timeout: tick_1hz=%b, required a tick within 8 cycles", tick_1hz);
    end
    @(negedge clk_50MHz);
  endtask

  task automatic test_reset();
    exp_t e;
    repeat (3) @(negedge clk_50MHz);
    checks++;
    if ({phase, light, remain, remain_bcd, tick_1hz} !== {3'd5, 6'b100100, 7'd2, 8'h02, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: ph=%0d light=%b rem=%0d bcd=%h tick=%b, required ph=5 light=100100 rem=2 bcd=02 tick=0",
               phase, light, remain, remain_bcd, tick_1hz);
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tick_1hz !== (i % 4 == 3)) begin
        errors++;
        $display("FAIL tick_pattern[%0d]: tick_1hz=%b, required %b", i, tick_1hz, (i % 4 == 3));
      end
      if (i == 4) begin
        checks++;
        if ({phase, light, remain} !== {3'd5, 6'b100100, 7'd1}) begin
          errors++;
          $display("FAIL reset_first_tick: ph=%0d light=%b rem=%0d, required ph=5 light=100100 rem=1", phase, light, remain);
        end
      end
      if (i < 7) @(negedge clk_50MHz);
    end
    sb.push_back(mk(3'd0, 30, 1'b0));
    while (sb.size() > 0) begin
      wait_tick();
      e = sb.pop_front();
      checks++;
      if ({phase, light, remain, remain_bcd} !== e) begin
        errors++;
        $display("FAIL reset_ns_g_entry: ph=%0d light=%b rem=%0d bcd=%h, required ph=%0d light=%b rem=%0d bcd=%h",
                 phase, light, remain, remain_bcd, e.ph, e.lt, e.rm, e.bcd);
      end
    end
  endtask

  task automatic test_full_cycle();
    exp_t e;
    push_run(3'd0, 29, 1);
    push_run(3'd1, 3, 1);
    push_run(3'd2, 2, 1);
    push_run(3'd3, 30, 1);
    push_run(3'd4, 3, 1);
    push_run(3'd5, 2, 1);
    sb.push_back(mk(3'd0, 30, 1'b0));
    while (sb.size() > 0) begin
      wait_tick();
      e = sb.pop_front();
      checks++;
      if ({phase, light, remain, remain_bcd} !== e) begin
        errors++;
        $display("FAIL full_cycle: ph=%0d light=%b rem=%0d bcd=%h, required ph=%0d light=%b rem=%0d bcd=%h",
                 phase, light, remain, remain_bcd, e.ph, e.lt, e.rm, e.bcd);
      end
    end
  endtask

  task automatic test_ped_shorten();
    exp_t e;
    bit found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (phase == 3'd0 && remain == 7'd20) found = 1;
      else wait_tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL ped_shorten_setup: ph=%0d rem=%0d, required NS_G rem=20", phase, remain);
    end
    ped_req_ns = 1'b1;
    @(negedge clk_50MHz);
    ped_req_ns = 1'b0;
    push_run(3'd0, 5, 1);
    push_run(3'd1, 3, 1);
    push_run(3'd2, 2, 1);
    push_run(3'd3, 30, 1);
    sb.push_back(mk(3'd4, 3, 1'b0));
    while (sb.size() > 0) begin
      wait_tick();
      e = sb.pop_front();
      checks++;
      if ({phase, light, remain, remain_bcd} !== e) begin
        errors++;
        $display("FAIL ped_shorten: ph=%0d light=%b rem=%0d bcd=%h, required ph=%0d light=%b rem=%0d bcd=%h",
                 phase, light, remain, remain_bcd, e.ph, e.lt, e.rm, e.bcd);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_50MHz);
    reset = 1'b1;
    @(negedge clk_50MHz);
    reset = 1'b0;
    checks++;
    if ({phase, light, remain, remain_bcd} !== {3'd5, 6'b100100, 7'd2, 8'h02}) begin
      errors++;
      $display("FAIL reset_mid: ph=%0d light=%b rem=%0d bcd=%h, required ph=5 light=100100 rem=2 bcd=02",
               phase, light, remain, remain_bcd);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tick_1hz !== (i == 3)) begin
        errors++;
        $display("FAIL reset_mid_tick[%0d]: tick_1hz=%b, required %b", i, tick_1hz, (i == 3));
      end
      if (i < 3) @(negedge clk_50MHz);
    end
  endtask

  task automatic test_ped_same_tick();
    exp_t e;
    int   n = 0;
    wait_tick();
    while (tick_1hz !== 1'b1 && n < 8) begin
      @(negedge clk_50MHz);
      n++;
    end
    checks++;
    if (n >= 8 || remain !== 7'd1 || phase !== 3'd5) begin
      errors++;
      $display("FAIL same_tick_setup: ph=%0d rem=%0d tick=%b, required RED_B rem=1 on a tick", phase, remain, tick_1hz);
    end
    ped_req_ew = 1'b1;
    @(negedge clk_50MHz);
    ped_req_ew = 1'b0;
    checks++;
    if ({phase, light, remain, remain_bcd} !== {3'd0, 6'b001100, 7'd30, 8'h30}) begin
      errors++;
      $display("FAIL same_tick_entry: ph=%0d light=%b rem=%0d bcd=%h, required ph=0 light=001100 rem=30 bcd=30",
               phase, light, remain, remain_bcd);
    end
    push_run(3'd0, 29, 1);
    push_run(3'd1, 3, 1);
    push_run(3'd2, 2, 1);
    sb.push_back(mk(3'd3, 30, 1'b0));
    push_run(3'd3, 5, 4);
    while (sb.size() > 0) begin
      wait_tick();
      e = sb.pop_front();
      checks++;
      if ({phase, light, remain, remain_bcd} !== e) begin
        errors++;
        $display("FAIL same_tick_pend_ew: ph=%0d light=%b rem=%0d bcd=%h, required ph=%0d light=%b rem=%0d bcd=%h",
                 phase, light, remain, remain_bcd, e.ph, e.lt, e.rm, e.bcd);
      end
    end
  endtask

  task automatic test_ped_late();
    exp_t e;
    bit found = 0;
    for (int n = 0; n < 60 && !found; n++) begin
      if (phase == 3'd0 && remain == 7'd3) found = 1;
      else wait_tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL ped_late_setup: ph=%0d rem=%0d, required NS_G rem=3", phase, remain);
    end
    ped_req_ns = 1'b1;
    @(negedge clk_50MHz);
    ped_req_ns = 1'b0;
    push_run(3'd0, 2, 1);
    sb.push_back(mk(3'd1, 3, 1'b0));
    while (sb.size() > 0) begin
      wait_tick();
      e = sb.pop_front();
      checks++;
      if ({phase, light, remain, remain_bcd} !== e) begin
        errors++;
        $display("FAIL ped_late: ph=%0d light=%b rem=%0d bcd=%h, required ph=%0d light=%b rem=%0d bcd=%h",
                 phase, light, remain, remain_bcd, e.ph, e.lt, e.rm, e.bcd);
      end
    end
  endtask

  task automatic test_night();
    exp_t e;
    bit found = 0;
    for (int n = 0; n < 60 && !found; n++) begin
      if (phase == 3'd3 && remain == 7'd20) found = 1;
      else wait_tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL night_setup: ph=%0d rem=%0d, required EW_G rem=20", phase, remain);
    end
    night = 1'b1;
    sb.push_back(mk(3'd6, 0, 1'b1));
    sb.push_back(mk(3'd6, 0, 1'b0));
    sb.push_back(mk(3'd6, 0, 1'b1));
    sb.push_back(mk(3'd6, 0, 1'b0));
    while (sb.size() > 0) begin
      wait_tick();
      e = sb.pop_front();
      checks++;
      if ({phase, light, remain, remain_bcd} !== e) begin
        errors++;
        $display("FAIL night_flash: ph=%0d light=%b rem=%0d bcd=%h, required ph=%0d light=%b rem=%0d bcd=%h",
                 phase, light, remain, remain_bcd, e.ph, e.lt, e.rm, e.bcd);
      end
    end
    night = 1'b0;
    push_run(3'd5, 2, 1);
    sb.push_back(mk(3'd0, 30, 1'b0));
    while (sb.size() > 0) begin
      wait_tick();
      e = sb.pop_front();
      checks++;
      if ({phase, light, remain, remain_bcd} !== e) begin
        errors++;
        $display("FAIL night_exit: ph=%0d light=%b rem=%0d bcd=%h, required ph=%0d light=%b rem=%0d bcd=%h",
                 phase, light, remain, remain_bcd, e.ph, e.lt, e.rm, e.bcd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_ped_shorten();
    test_reset_mid();
    test_ped_same_tick();
    test_ped_late();
    test_night();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
